// File: rtl/pe_chain_ctrl.sv
// pe_chain_ctrl: weight loader, pixel streamer and drain sequencer
// for a linear PE chain that shares one global pe_en.
module pe_chain_ctrl #(
    parameter int NUM_PE       = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 1,
    parameter int PIPE_DEPTH   = 4,
    parameter int LEN_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic                           reload_w,
    input  logic [LEN_WIDTH-1:0]           num_pixels,
    output logic                           busy,
    output logic                           done,
    input  logic                           w_valid,
    input  logic [WEIGHT_WIDTH-1:0]        w_data,
    output logic                           w_ready,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           in_ready,
    output logic                           pe_en,
    output logic [DATA_WIDTH-1:0]          pe_data,
    output logic [NUM_PE*WEIGHT_WIDTH-1:0] pe_weights,
    input  logic [DATA_WIDTH+WEIGHT_WIDTH:0] chain_result,
    output logic                           out_valid,
    output logic [DATA_WIDTH+WEIGHT_WIDTH:0] out_data,
    input  logic                           out_ready
);
    localparam int CW  = LEN_WIDTH + 1;
    localparam int WCW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [CW-1:0]  PD     = CW'(PIPE_DEPTH);
    localparam logic [WCW-1:0] W_LAST = WCW'(NUM_PE - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, RUN, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  len_q, len_d;
    logic [CW-1:0]                  step_q, step_d;
    logic [WCW-1:0]                 w_cnt_q, w_cnt_d;
    logic [NUM_PE*WEIGHT_WIDTH-1:0] wts_q, wts_d;
    logic                           out_valid_q, out_valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           w_ready_q, w_ready_d;
    logic                           stall, adv, drain_end;

    assign stall     = out_valid_q && !out_ready;
    assign drain_end = (step_q == len_q + PD);

    always_comb begin
        adv      = 1'b0;
        in_ready = 1'b0;
        pe_data  = '0;
        unique case (state_q)
            RUN: begin
                in_ready = !stall;
                adv      = in_valid && !stall;
                pe_data  = in_data;
            end
            DRAIN:   adv = !stall && !drain_end;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        step_d  = step_q;
        w_cnt_d = w_cnt_q;
        wts_d   = wts_q;
        if (adv) step_d = step_q + CW'(1);
        // a result is only real once the first pixel reached the tail
        if (adv && step_q >= PD) out_valid_d = 1'b1;
        else if (out_valid_q && out_ready) out_valid_d = 1'b0;
        else out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: if (start) begin
                len_d  = {1'b0, num_pixels};
                step_d = '0;
                if (num_pixels == '0) state_d = DONE;
                else if (reload_w)    state_d = LOAD_W;
                else                  state_d = RUN;
            end
            LOAD_W: if (w_valid) begin
                for (int i = 0; i < NUM_PE; i++)
                    if (w_cnt_q == WCW'(i))
                        wts_d[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_data;
                if (w_cnt_q == W_LAST) begin
                    w_cnt_d = '0;
                    state_d = RUN;
                end else begin
                    w_cnt_d = w_cnt_q + WCW'(1);
                end
            end
            RUN: if (adv && step_q == len_q - CW'(1)) state_d = DRAIN;
            DRAIN: if (drain_end && (!out_valid_q || out_ready))
                state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        w_ready_d = (state_d == LOAD_W);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            step_q      <= '0;
            w_cnt_q     <= '0;
            wts_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            step_q      <= step_d;
            w_cnt_q     <= w_cnt_d;
            wts_q       <= wts_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_ready_q   <= w_ready_d;
        end
    end

    assign pe_en      = adv;
    assign pe_weights = wts_q;
    assign out_valid  = out_valid_q;
    assign out_data   = chain_result;
    assign busy       = busy_q;
    assign done       = done_q;
    assign w_ready    = w_ready_q;
endmodule
